tdp_ram: RTL

TDP_RAM -- requirements
Module: tdp_ram

---
 rtl/tdp_ram_pkg.sv | 19 +
 rtl/tdp_ram_port.sv | 97 +++++++++
 rtl/tdp_ram.sv | 132 +++++++++++++
 3 files changed

// File: rtl/tdp_ram_pkg.sv
// tdp_ram_pkg: shared constants for the true dual-port RAM.
//   - Read-during-write mode encodings used by the A_MODE / B_MODE parameters.
//   - Collision counter width and its saturating increment helper.
package tdp_ram_pkg;

  // Read-during-write behaviour of a port on a write cycle
  localparam int unsigned READ_FIRST  = 0;
  localparam int unsigned WRITE_FIRST = 1;
  localparam int unsigned NO_CHANGE   = 2;

  localparam int unsigned COLL_CNT_W = 16;
  localparam logic [COLL_CNT_W-1:0] COLL_CNT_MAX = '1;

  // Increment that sticks at all-ones instead of wrapping
  function automatic logic [COLL_CNT_W-1:0] sat_inc(input logic [COLL_CNT_W-1:0] val);
    return (val == COLL_CNT_MAX) ? val : val + 1'b1;
  endfunction

endpackage

// File: rtl/tdp_ram_port.sv
// tdp_ram_port: per-port read-data path of tdp_ram.
//   Builds the byte-merged post-write word, selects the returned word according
//   to the read-during-write MODE, and registers rdata/rvalid (one stage, or two
//   when TDP_RAM_OUT_REG_EN is defined).
// Ports:
//   clk, rst        clock, synchronous active-high reset (clears every stage)
//   en, we, be      access enable, write strobe, byte enables
//   wdata           write data (only used for the WRITE_FIRST merge here)
//   mem_word        current memory word at this port's address (pre-write)
//   rdata, rvalid   read data and its valid flag
module tdp_ram_port import tdp_ram_pkg::*; #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned MODE   = READ_FIRST
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                we,
  input  logic [DATA_W/8-1:0] be,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W-1:0]   mem_word,
  output logic [DATA_W-1:0]   rdata,
  output logic                rvalid
);

  localparam int unsigned NB = DATA_W / 8;

  logic [DATA_W-1:0] merged;
  logic [DATA_W-1:0] rdata_d, rdata_q;
  logic              rvalid_d, rvalid_q;

  // Word as it will look after this port's write
  always_comb begin
    merged = mem_word;
    for (int i = 0; i < NB; i++) begin
      if (be[i]) merged[i*8 +: 8] = wdata[i*8 +: 8];
    end
  end

  always_comb begin
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
    if (en) begin
      if (!we) begin
        rdata_d  = mem_word;
        rvalid_d = 1'b1;
      end else begin
        case (MODE)
          WRITE_FIRST: begin
            rdata_d  = merged;
            rvalid_d = 1'b1;
          end
          NO_CHANGE: begin
            rdata_d  = rdata_q;
            rvalid_d = 1'b0;
          end
          default: begin
            rdata_d  = mem_word;
            rvalid_d = 1'b1;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

`ifdef TDP_RAM_OUT_REG_EN
  logic [DATA_W-1:0] rdata_q2;
  logic              rvalid_q2;

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q2  <= '0;
      rvalid_q2 <= 1'b0;
    end else begin
      rdata_q2  <= rdata_q;
      rvalid_q2 <= rvalid_q;
    end
  end

  assign rdata  = rdata_q2;
  assign rvalid = rvalid_q2;
`else
  assign rdata  = rdata_q;
  assign rvalid = rvalid_q;
`endif

endmodule

// File: rtl/tdp_ram.sv
// tdp_ram: true dual-port RAM, byte-enabled, one clock, configurable
// read-during-write behaviour per port, with same-address collision detection.
// Optional macro TDP_RAM_OUT_REG_EN adds an output register per port (and on
// coll), raising read latency from 1 to 2 cycles.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//                             (clears outputs and counter, not memory)
//   a_en/a_we/a_be/a_addr/a_wdata  port A request
//   a_rdata/a_rvalid          port A read data / valid
//   b_*                       port B, identical to port A
//   coll                      one-cycle pulse after each collision
//   coll_cnt                  saturating collision count
module tdp_ram import tdp_ram_pkg::*; #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned A_MODE = READ_FIRST,
  parameter int unsigned B_MODE = READ_FIRST
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  a_en,
  input  logic                  a_we,
  input  logic [DATA_W/8-1:0]   a_be,
  input  logic [ADDR_W-1:0]     a_addr,
  input  logic [DATA_W-1:0]     a_wdata,
  output logic [DATA_W-1:0]     a_rdata,
  output logic                  a_rvalid,
  input  logic                  b_en,
  input  logic                  b_we,
  input  logic [DATA_W/8-1:0]   b_be,
  input  logic [ADDR_W-1:0]     b_addr,
  input  logic [DATA_W-1:0]     b_wdata,
  output logic [DATA_W-1:0]     b_rdata,
  output logic                  b_rvalid,
  output logic                  coll,
  output logic [COLL_CNT_W-1:0] coll_cnt
);

  localparam int unsigned NB    = DATA_W / 8;
  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [DATA_W-1:0] a_word, b_word;
  logic              a_wr, b_wr;
  logic              coll_hit;
  logic              coll_q;
  logic [COLL_CNT_W-1:0] coll_cnt_q;

  assign a_wr = a_en & a_we;
  assign b_wr = b_en & b_we;

  // Pre-write words; a reading port in a read/write collision sees old data
  assign a_word = mem[a_addr];
  assign b_word = mem[b_addr];

  // B is applied first so that A's bytes override on a same-address write;
  // B's bytes land only where A's byte enable is clear.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (b_wr) begin
        for (int i = 0; i < NB; i++) begin
          if (b_be[i]) mem[b_addr][i*8 +: 8] <= b_wdata[i*8 +: 8];
        end
      end
      if (a_wr) begin
        for (int i = 0; i < NB; i++) begin
          if (a_be[i]) mem[a_addr][i*8 +: 8] <= a_wdata[i*8 +: 8];
        end
      end
    end
  end

  tdp_ram_port #(
    .DATA_W (DATA_W),
    .MODE   (A_MODE)
  ) u_port_a (
    .clk      (clk),
    .rst      (rst),
    .en       (a_en),
    .we       (a_we),
    .be       (a_be),
    .wdata    (a_wdata),
    .mem_word (a_word),
    .rdata    (a_rdata),
    .rvalid   (a_rvalid)
  );

  tdp_ram_port #(
    .DATA_W (DATA_W),
    .MODE   (B_MODE)
  ) u_port_b (
    .clk      (clk),
    .rst      (rst),
    .en       (b_en),
    .we       (b_we),
    .be       (b_be),
    .wdata    (b_wdata),
    .mem_word (b_word),
    .rdata    (b_rdata),
    .rvalid   (b_rvalid)
  );

  assign coll_hit = a_en & b_en & (a_addr == b_addr) & (a_we | b_we);

  always_ff @(posedge clk) begin
    if (rst) begin
      coll_q     <= 1'b0;
      coll_cnt_q <= '0;
    end else begin
      coll_q <= coll_hit;
      if (coll_hit) coll_cnt_q <= sat_inc(coll_cnt_q);
    end
  end

  assign coll_cnt = coll_cnt_q;

`ifdef TDP_RAM_OUT_REG_EN
  // Keep coll aligned with the registered read data
  logic coll_q2;

  always_ff @(posedge clk) begin
    if (rst) coll_q2 <= 1'b0;
    else     coll_q2 <= coll_q;
  end

  assign coll = coll_q2;
`else
  assign coll = coll_q;
`endif

endmodule
